amba_req_arbiter: RTL

- Round-robin arbiter that shares one amba_master instruction port between NREQ requesters (DMA, CPU shim, test driver).
- Selects one requester per address phase and holds the grant across multi-beat bursts.
- Tracks the AHB data-phase owner and routes read data and write-completion pulses back to the requester that issued each transfer.
- Sits between requester queues and amba_master; amba_master's ports connect directly to this block's master-side ports.

---
 rtl/amba_pkg.sv | 28 ++
 rtl/amba_req_arbiter_picker.sv | 33 +++
 rtl/amba_req_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/amba_pkg.sv
// Shared AHB definitions: bus widths, instruction word layout and transfer enums.
package amba_pkg;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 32;

  // Instruction word, MSB first: {hwrite, hsize[2:0], htrans[1:0], addr, data}
  localparam int IWIDTH     = DWIDTH + AWIDTH + 6;
  localparam int ADDR_LSB   = DWIDTH;
  localparam int HTRANS_LSB = DWIDTH + AWIDTH;
  localparam int HSIZE_LSB  = HTRANS_LSB + 2;
  localparam int HWRITE_POS = HSIZE_LSB + 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_t;

endpackage

// File: rtl/amba_req_arbiter_picker.sv
// Combinational round-robin picker: first asserted request after last_i, with wrap.
module amba_rr_picker #(
  parameter int NREQ = 4,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [LW-1:0]   idx_o,
  output logic            any_o
);

  logic [LW-1:0] cand;
  logic          found;

  // Walk the ring starting one past the previous winner; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/amba_req_arbiter.sv
// Round-robin arbiter sharing one amba_master port between NREQ requesters.
// Holds the grant across bursts and routes data-phase responses to the issuer.
//
// Handshake: a requester's instruction transfers on a rising edge where
// req_valid[i] and req_ready[i] are both high; req_ready is combinational
// (grant & amba_en & instr_rd), so the requester advances on that same edge.
module amba_req_arbiter
  import amba_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = amba_pkg::DWIDTH,
  parameter int AWIDTH = amba_pkg::AWIDTH,
  parameter int IWIDTH = DWIDTH + AWIDTH + 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*IWIDTH-1:0] req_instr,
  output logic [NREQ-1:0]        req_ready,
  output logic [IWIDTH-1:0]      amba_instr,
  output logic                   amba_en,
  input  logic                   instr_rd,
  input  logic                   amba_wr_flg,
  input  logic [DWIDTH-1:0]      amba_slv_data,
  input  logic [AWIDTH-1:0]      amba_slv_addr,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_data,
  output logic [AWIDTH-1:0]      rsp_addr,
  output logic [NREQ-1:0]        wdone,
  output logic                   busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Field positions follow the package layout, shifted if the widths are overridden.
  localparam int SHIFT    = (DWIDTH + AWIDTH) - (amba_pkg::DWIDTH + amba_pkg::AWIDTH);
  localparam int TRANS_HI = HTRANS_LSB + SHIFT + 1;
  localparam int WR_BIT   = HWRITE_POS + SHIFT;

  logic              lock_q, lock_d;
  logic [LW-1:0]     owner_q, owner_d;
  logic [LW-1:0]     last_grant_q, last_grant_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [LW-1:0]     dp_owner_q, dp_owner_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [AWIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [NREQ-1:0]   wdone_q, wdone_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [LW-1:0]     pick_idx;
  logic              pick_any;

  logic [LW-1:0]     sel;
  logic [NREQ-1:0]   grant_w;
  logic              granted;
  logic [IWIDTH-1:0] sel_instr;
  logic              accept;

  amba_rr_picker #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_picker (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A locked burst owner keeps the port even while its req_valid is low.
  always_comb begin
    grant_w = '0;
    if (lock_q) begin
      sel              = owner_q;
      grant_w[owner_q] = 1'b1;
      granted          = 1'b1;
    end else begin
      sel     = pick_idx;
      grant_w = pick_gnt;
      granted = pick_any;
    end
  end

  assign sel_instr  = req_instr[int'(sel)*IWIDTH +: IWIDTH];
  assign amba_en    = granted & req_valid[sel];
  assign amba_instr = granted ? sel_instr : '0;
  assign accept     = amba_en & instr_rd;
  assign req_ready  = accept ? grant_w : '0;

  // Next state: arbitration on accept, data-phase tracking and responses on hready.
  always_comb begin
    lock_d       = lock_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_owner_d   = dp_owner_q;
    rsp_valid_d  = '0;
    wdone_d      = '0;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;

    if (accept) begin
      last_grant_d = sel;
      owner_d      = sel;
      lock_d       = ~req_last[sel];
    end

    if (instr_rd) begin
      // IDLE/BUSY beats (htrans[1]=0) never open a data phase.
      dp_valid_d = accept & sel_instr[TRANS_HI];
      if (accept) begin
        dp_write_d = sel_instr[WR_BIT];
        dp_owner_d = sel;
      end
      if (dp_valid_q && !dp_write_q && amba_wr_flg) begin
        rsp_valid_d[dp_owner_q] = 1'b1;
        rsp_data_d              = amba_slv_data;
        rsp_addr_d              = amba_slv_addr;
      end
      if (dp_valid_q && dp_write_q) begin
        wdone_d[dp_owner_q] = 1'b1;
      end
    end
  end

  // State registers; reset drops any in-flight data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      owner_q      <= '0;
      last_grant_q <= LW'(NREQ - 1);
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_owner_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      wdone_q      <= '0;
    end else begin
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_owner_q   <= dp_owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      wdone_q      <= wdone_d;
    end
  end

  assign grant     = grant_w;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign wdone     = wdone_q;
  assign busy      = lock_q | dp_valid_q;

endmodule
